// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned CntWDefault = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: shadow/active divide, period counter, FSM and registered outputs.
module clock_divider_ch
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] divide,
  input  logic             load,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             cfg_err
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] s_eff;
  logic             err_q, err_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             s_ok, wrap, set_err;
  logic [CNT_W:0]   high_d;

  always_comb begin
    // A load coinciding with a wrap or sync takes effect immediately.
    s_eff    = load ? divide : shadow_q;
    shadow_d = s_eff;
    s_ok     = (s_eff >= CNT_W'(2));
    wrap     = (cnt_q == act_q - CNT_W'(1));
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    set_err  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          if (s_ok) begin
            state_d = StRun;
            act_d   = s_eff;
            cnt_d   = '0;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      StRun, StDrain: begin
        if (sync) begin
          // An unusable shadow on sync restarts with the current period instead.
          cnt_d   = '0;
          state_d = en ? StRun : StDrain;
          if (s_ok) act_d = s_eff;
          else      set_err = 1'b1;
        end else if (wrap) begin
          cnt_d = '0;
          if (!en) begin
            state_d = StIdle;
          end else if (!s_ok) begin
            state_d = StIdle;
            set_err = 1'b1;
          end else begin
            state_d = StRun;
            act_d   = s_eff;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = en ? StRun : StDrain;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    err_d     = set_err | (err_q & ~(load & (divide >= CNT_W'(2))));
    high_d    = ({1'b0, act_d} + (CNT_W + 1)'(1)) >> 1;
    clk_out_d = (state_d != StIdle) && ({1'b0, cnt_d} < high_d);
    tick_d    = (state_d != StIdle) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      act_q     <= '0;
      shadow_q  <= '0;
      err_q     <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shadow_q  <= shadow_d;
      err_q     <= err_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign running = (state_q != StIdle);
  assign cfg_err = err_q;

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider: NUM_CH independent channels with shared sync.
module clock_divider_mc
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] divide,
  input  logic [NUM_CH-1:0]       load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       cfg_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .divide (divide[i*CNT_W +: CNT_W]),
      .load   (load[i]),
      .sync   (sync),
      .clk_out(clk_out[i]),
      .tick   (tick[i]),
      .running(running[i]),
      .cfg_err(cfg_err[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Directed bench for clock_divider_mc: vector table on channel 0 plus multi-cycle sequences.
module tb_clock_divider_mc;

  localparam int unsigned NumCh = 4;
  localparam int unsigned CntW  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NumCh-1:0]       en;
  logic [NumCh*CntW-1:0]  divide;
  logic [NumCh-1:0]       load;
  logic                   sync;
  logic [NumCh-1:0]       clk_out, tick, running, cfg_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic            en;
    logic            load;
    logic [CntW-1:0] div;
    logic [3:0]      exp;  // {clk_out, tick, running, cfg_err}
  } vec_t;

  vec_t vq[$];

  clock_divider_mc #(
    .NUM_CH(NumCh),
    .CNT_W (CntW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .divide (divide),
    .load   (load),
    .sync   (sync),
    .clk_out(clk_out),
    .tick   (tick),
    .running(running),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  function automatic logic [3:0] ch_outs(input int ch);
    return {clk_out[ch], tick[ch], running[ch], cfg_err[ch]};
  endfunction

  initial begin
    logic [7:0] exp_c8, exp_t8;
    logic [6:0] exp_c7, exp_r7;

    // Ch0 vectors: divide 4 -> 5 -> (wrap+load) 2, stop, bad divide 1, then 3 with drain.
    vq.push_back('{1'b0, 1'b1, 16'd4, 4'b0000});
    vq.push_back('{1'b1, 1'b0, 16'd4, 4'b1110});
    vq.push_back('{1'b1, 1'b0, 16'd4, 4'b1010});
    vq.push_back('{1'b1, 1'b0, 16'd4, 4'b0010});
    vq.push_back('{1'b1, 1'b0, 16'd4, 4'b0010});
    vq.push_back('{1'b1, 1'b0, 16'd4, 4'b1110});
    vq.push_back('{1'b1, 1'b0, 16'd4, 4'b1010});
    vq.push_back('{1'b1, 1'b0, 16'd4, 4'b0010});
    vq.push_back('{1'b1, 1'b1, 16'd5, 4'b0010});
    vq.push_back('{1'b1, 1'b0, 16'd5, 4'b1110});
    vq.push_back('{1'b1, 1'b0, 16'd5, 4'b1010});
    vq.push_back('{1'b1, 1'b0, 16'd5, 4'b1010});
    vq.push_back('{1'b1, 1'b0, 16'd5, 4'b0010});
    vq.push_back('{1'b1, 1'b0, 16'd5, 4'b0010});
    vq.push_back('{1'b1, 1'b1, 16'd2, 4'b1110});
    vq.push_back('{1'b1, 1'b0, 16'd2, 4'b0010});
    vq.push_back('{1'b1, 1'b0, 16'd2, 4'b1110});
    vq.push_back('{1'b1, 1'b0, 16'd2, 4'b0010});
    vq.push_back('{1'b0, 1'b0, 16'd2, 4'b0000});
    vq.push_back('{1'b0, 1'b0, 16'd2, 4'b0000});
    vq.push_back('{1'b1, 1'b1, 16'd1, 4'b0001});
    vq.push_back('{1'b1, 1'b0, 16'd1, 4'b0001});
    vq.push_back('{1'b1, 1'b1, 16'd3, 4'b1110});
    vq.push_back('{1'b1, 1'b0, 16'd3, 4'b1010});
    vq.push_back('{1'b1, 1'b0, 16'd3, 4'b0010});
    vq.push_back('{1'b1, 1'b0, 16'd3, 4'b1110});
    vq.push_back('{1'b0, 1'b0, 16'd3, 4'b1010});
    vq.push_back('{1'b0, 1'b0, 16'd3, 4'b0010});
    vq.push_back('{1'b0, 1'b0, 16'd3, 4'b0000});

    rst    = 1'b1;
    en     = '0;
    divide = '0;
    load   = '0;
    sync   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {clk_out, tick, running, cfg_err}, 16'h0);
    rst = 1'b0;
    cycle();
    chk("post_reset_idle", {clk_out, tick, running, cfg_err}, 16'h0);

    for (int i = 0; i < vq.size(); i++) begin
      en[0]          = vq[i].en;
      load[0]        = vq[i].load;
      divide[15:0]   = vq[i].div;
      cycle();
      chk($sformatf("vec%0d", i), {12'h0, ch_outs(0)}, {12'h0, vq[i].exp});
    end
    load[0] = 1'b0;

    // Reload mid-period: N=4 period completes, next period is 111000.
    en[0] = 1'b1; load[0] = 1'b1; divide[15:0] = 16'd4;
    cycle();
    chk("reload_start", {12'h0, ch_outs(0)}, 16'b1110);
    load[0] = 1'b0;
    cycle();
    chk("reload_c1", {12'h0, ch_outs(0)}, 16'b1010);
    load[0] = 1'b1; divide[15:0] = 16'd6;
    cycle();
    chk("reload_c2", {15'h0, clk_out[0]}, 16'h0);
    load[0] = 1'b0;
    exp_c8 = 8'b1000_1110;
    exp_t8 = 8'b1000_0010;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk($sformatf("reload_seq%0d", i), {14'h0, clk_out[0], tick[0]},
          {14'h0, exp_c8[i], exp_t8[i]});
    end

    // Sync into N=8, then drop en at C=2: 11110000 completes, then idle.
    load[0] = 1'b1; divide[15:0] = 16'd8;
    cycle();
    chk("pre_sync_c1", {12'h0, ch_outs(0)}, 16'b1010);
    load[0] = 1'b0; sync = 1'b1;
    cycle();
    chk("sync_restart", {12'h0, ch_outs(0)}, 16'b1110);
    sync = 1'b0;
    cycle();
    cycle();
    chk("drain_c2", {12'h0, ch_outs(0)}, 16'b1010);
    en[0] = 1'b0;
    exp_c7 = 7'b000_0001;
    exp_r7 = 7'b001_1111;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk($sformatf("drain_seq%0d", i), {14'h0, clk_out[0], running[0]},
          {14'h0, exp_c7[i], exp_r7[i]});
    end

    // Cross-channel sync: ch0 N=4, ch1 N=6 out of phase, then aligned.
    en[1:0] = 2'b11; load[1:0] = 2'b11;
    divide[15:0] = 16'd4; divide[31:16] = 16'd6;
    cycle();
    load[1:0] = 2'b00;
    cycle();
    cycle();
    chk("phase_before_sync", {14'h0, clk_out[1:0]}, 16'b10);
    sync = 1'b1;
    cycle();
    chk("sync_both", {12'h0, clk_out[1:0], tick[1:0]}, 16'b1111);
    chk("sync_idle_ch2", {12'h0, ch_outs(2)}, 16'h0);
    sync = 1'b0;
    cycle();
    chk("sync_after", {12'h0, clk_out[1:0], tick[1:0]}, 16'b1100);

    // Bad shadow loaded mid-period on ch1: period finishes, then idle with cfg_err.
    load[1] = 1'b1; divide[31:16] = 16'd0;
    cycle();
    load[1] = 1'b0;
    repeat (3) cycle();
    chk("bad_shadow_c5", {12'h0, ch_outs(1)}, 16'b0010);
    cycle();
    chk("bad_shadow_idle", {12'h0, ch_outs(1)}, 16'b0001);

    // Asynchronous reset mid-period.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {clk_out, tick, running, cfg_err}, 16'h0);
    @(negedge clk);
    en = '0;
    rst = 1'b0;
    repeat (3) begin
      cycle();
      chk("idle_after_reset", {clk_out, tick, running, cfg_err}, 16'h0);
    end
    en[0] = 1'b1;
    cycle();
    chk("shadow_cleared", {12'h0, ch_outs(0)}, 16'b0001);
    load[0] = 1'b1; divide[15:0] = 16'd4;
    cycle();
    chk("restart_after_reset", {12'h0, ch_outs(0)}, 16'b1110);
    load[0] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
